// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity polarity and line levels.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity generator: par_type 0 = even, 1 = odd.
// Shared with receive-side reference models.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  par_bit
);

    assign par_bit = (par_type == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;
    logic                  par_bit;

    // Parity comes from the latched byte so it is unaffected by shifting.
    uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data     (data_q),
        .par_type (par_type_q),
        .par_bit  (par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        bit_end    = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d    = START;
                    cnt_d      = '0;
                    bit_d      = '0;
                    shreg_d    = p_data;
                    data_d     = p_data;
                    par_en_d   = par_en;
                    par_type_d = par_type;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    // bit_q counts stop bits already sent.
                    if (bit_q == '0) begin
                        bit_d = BIT_W'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_bit;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
